// File: rtl/kbd_cmd_pkg.sv
// Mode encodings and common PS/2 set-2 scancodes shared by the keyboard command decoder.
package kbd_cmd_pkg;

  localparam logic [1:0] MODE_PULSE  = 2'd0;
  localparam logic [1:0] MODE_LEVEL  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic [7:0] KEY_SPACE  = 8'h29;
  localparam logic [7:0] KEY_ESC    = 8'h76;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;
  localparam logic [7:0] KEY_1      = 8'h16;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;

endpackage

// File: rtl/kbd_cmd_channel.sv
// One command channel (PULSE/LEVEL/TOGGLE/HOLD chosen by MODE); outputs registered, 1 clock after kbData.
// KEY_REPEAT_EN adds auto-repeat to PULSE channels; without it PULSE fires once per press.
module kbd_cmd_channel
  import kbd_cmd_pkg::*;
#(
  parameter logic [7:0] CODE        = KEY_ENTER,
  parameter logic [1:0] MODE        = MODE_PULSE,
  parameter int         HOLD_CYCLES = 25000000
`ifdef KEY_REPEAT_EN
  ,
  parameter int         REPEAT_DELAY  = 12500000,
  parameter int         REPEAT_PERIOD = 2500000
`endif
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [7:0] kb_data,
  input  logic [7:0] prev_code,
  input  logic       chan_en,
  input  logic       clr,
  output logic       cmd,
  output logic       held
);

  localparam int            HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

`ifdef KEY_REPEAT_EN
  localparam int            RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW    = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_D = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_P = RW'(REPEAT_PERIOD);
  logic [RW-1:0] rep_cnt;
  logic          rep_phase;
`endif

  logic          match_now, match_prev, press, rel;
  logic          armed;
  logic [HW-1:0] hold_cnt;

  // A zero scancode can never match: code 0 disables the channel.
  assign match_now  = (kb_data != 8'h00) && (kb_data == CODE);
  assign match_prev = (prev_code != 8'h00) && (prev_code == CODE);
  assign press      = match_now && !match_prev;
  assign rel        = match_prev && !match_now;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      cmd      <= 1'b0;
      held     <= 1'b0;
      armed    <= 1'b0;
      hold_cnt <= '0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      held <= match_now;
      case (MODE)
        MODE_PULSE: begin
`ifdef KEY_REPEAT_EN
          // rep_cnt == 0 means idle; it only runs after a press that actually fired.
          if (clr) begin
            cmd       <= 1'b0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
          end else if (press && chan_en) begin
            cmd       <= 1'b1;
            rep_cnt   <= RW'(1);
            rep_phase <= 1'b0;
          end else if ((rep_cnt != '0) && match_now && chan_en) begin
            if (rep_cnt == (rep_phase ? REP_P : REP_D)) begin
              cmd       <= 1'b1;
              rep_cnt   <= RW'(1);
              rep_phase <= 1'b1;
            end else begin
              cmd     <= 1'b0;
              rep_cnt <= rep_cnt + 1'b1;
            end
          end else begin
            cmd       <= 1'b0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
          end
`else
          cmd <= !clr && press && chan_en;
`endif
        end
        MODE_LEVEL: cmd <= !clr && match_now && chan_en;
        MODE_TOGGLE: begin
          // armed is deliberately not cleared by chan_en falling.
          if (clr) begin
            cmd   <= 1'b0;
            armed <= 1'b0;
          end else if (press && chan_en) begin
            armed <= 1'b1;
          end else if (rel && armed) begin
            cmd   <= ~cmd;
            armed <= 1'b0;
          end
        end
        default: begin
          if (!clr && match_now && chan_en) begin
            cmd      <= (hold_cnt == HOLD_LAST);
            hold_cnt <= (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
          end else begin
            cmd      <= 1'b0;
            hold_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/kbd_cmd_decoder.sv
// Maps the held PS/2 scancode onto NUM_KEYS command channels; all outputs registered, 1 clock latency.
// KEY_REPEAT_EN enables auto-repeat on PULSE channels (REPEAT_DELAY / REPEAT_PERIOD exist only then).
module kbd_cmd_decoder
  import kbd_cmd_pkg::*;
#(
  parameter int                    NUM_KEYS    = 5,
  parameter logic [NUM_KEYS*8-1:0] SCAN_CODES  = {KEY_ESC, KEY_SPACE, KEY_RSHIFT, KEY_1, KEY_ENTER},
  parameter logic [NUM_KEYS*2-1:0] MODES       = {MODE_TOGGLE, MODE_LEVEL, MODE_PULSE, MODE_PULSE, MODE_PULSE},
  parameter int                    HOLD_CYCLES = 25000000
`ifdef KEY_REPEAT_EN
  ,
  parameter int                    REPEAT_DELAY  = 12500000,
  parameter int                    REPEAT_PERIOD = 2500000
`endif
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic [7:0]          kbData,
  input  logic [NUM_KEYS-1:0] chan_en,
  input  logic [NUM_KEYS-1:0] clr,
  output logic [NUM_KEYS-1:0] cmd,
  output logic [NUM_KEYS-1:0] held,
  output logic                any_key
);

  logic [7:0] prev_code;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      prev_code <= 8'h00;
      any_key   <= 1'b0;
    end else begin
      prev_code <= kbData;
      any_key   <= (kbData != 8'h00);
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    kbd_cmd_channel #(
      .CODE        (SCAN_CODES[8*i +: 8]),
      .MODE        (MODES[2*i +: 2]),
      .HOLD_CYCLES (HOLD_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .Clock     (Clock),
      .reset     (reset),
      .kb_data   (kbData),
      .prev_code (prev_code),
      .chan_en   (chan_en[i]),
      .clr       (clr[i]),
      .cmd       (cmd[i]),
      .held      (held[i])
    );
  end

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Self-checking bench: directed scenarios plus random key sequences against a run-length reference model.
module tb_kbd_cmd_decoder;
  import kbd_cmd_pkg::*;

  localparam int NK   = 7;
  localparam int HOLD = 4;
`ifdef KEY_REPEAT_EN
  localparam int RDLY = 8;
  localparam int RPER = 3;
`endif
  // ch5 shares ENTER with ch0 (HOLD mode); ch6 has code 0 (disabled).
  localparam logic [NK*8-1:0] CODES   = {8'h00, KEY_ENTER, KEY_ESC, KEY_SPACE, KEY_RSHIFT, KEY_1, KEY_ENTER};
  localparam logic [NK*2-1:0] MODES_P = {MODE_LEVEL, MODE_HOLD, MODE_TOGGLE, MODE_LEVEL,
                                         MODE_PULSE, MODE_PULSE, MODE_PULSE};

  logic          Clock = 1'b0;
  logic          reset;
  logic [7:0]    kbData;
  logic [NK-1:0] chan_en, clr, cmd, held;
  logic          any_key;

  kbd_cmd_decoder #(
    .NUM_KEYS    (NK),
    .SCAN_CODES  (CODES),
    .MODES       (MODES_P),
    .HOLD_CYCLES (HOLD)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY  (RDLY),
    .REPEAT_PERIOD (RPER)
`endif
  ) dut (
    .Clock   (Clock),
    .reset   (reset),
    .kbData  (kbData),
    .chan_en (chan_en),
    .clr     (clr),
    .cmd     (cmd),
    .held    (held),
    .any_key (any_key)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [NK-1:0] cmd;
    logic [NK-1:0] held;
    logic          any;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   win = 1'b0;
  int   win_bit = 0;
  int   win_cnt = 0;
  int   held_cnt = 0;

  // Reference model state: run lengths instead of counters.
  logic [7:0] m_prev;
  int         run_p[NK];
  int         run_h[NK];
  bit         armed_m[NK];
  bit         tog_m[NK];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 8'h00;
    for (int i = 0; i < NK; i++) begin
      run_p[i]   = -1;
      run_h[i]   = 0;
      armed_m[i] = 1'b0;
      tog_m[i]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic [7:0] kb, input logic [NK-1:0] en, input logic [NK-1:0] cl);
    exp_t       e;
    logic [7:0] code;
    bit         now, was, press, rel, fire;
    e = '0;
    for (int i = 0; i < NK; i++) begin
      code  = CODES[8*i +: 8];
      now   = (code != 8'h00) && (kb == code);
      was   = (code != 8'h00) && (m_prev == code);
      press = now && !was;
      rel   = was && !now;
      e.held[i] = now;
      case (MODES_P[2*i +: 2])
        MODE_PULSE: begin
          fire = 1'b0;
          if (cl[i]) run_p[i] = -1;
          else if (press && en[i]) begin
            run_p[i] = 0;
            fire     = 1'b1;
          end else if (run_p[i] >= 0 && now && en[i]) begin
            run_p[i]++;
`ifdef KEY_REPEAT_EN
            fire = (run_p[i] >= RDLY) && (((run_p[i] - RDLY) % RPER) == 0);
`endif
          end else run_p[i] = -1;
          e.cmd[i] = fire;
        end
        MODE_LEVEL: e.cmd[i] = now && en[i] && !cl[i];
        MODE_TOGGLE: begin
          if (cl[i]) begin
            tog_m[i]   = 1'b0;
            armed_m[i] = 1'b0;
          end else begin
            if (press && en[i]) armed_m[i] = 1'b1;
            if (rel && armed_m[i]) begin
              tog_m[i]   = !tog_m[i];
              armed_m[i] = 1'b0;
            end
          end
          e.cmd[i] = tog_m[i];
        end
        default: begin
          if (cl[i] || !(now && en[i])) run_h[i] = 0;
          else if (run_h[i] < HOLD) run_h[i]++;
          e.cmd[i] = (run_h[i] >= HOLD);
        end
      endcase
    end
    e.any  = (kb != 8'h00);
    m_prev = kb;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [7:0] kb, input logic [NK-1:0] en, input logic [NK-1:0] cl);
    kbData  = kb;
    chan_en = en;
    clr     = cl;
    @(posedge Clock);
    model_step(kb, en, cl);
    #1;
  endtask

  task automatic hold(input logic [7:0] kb, input logic [NK-1:0] en, input int n);
    repeat (n) cyc(kb, en, '0);
  endtask

  task automatic win_start(input int b);
    win_bit  = b;
    win_cnt  = 0;
    held_cnt = 0;
    win      = 1'b1;
  endtask

  task automatic win_stop();
    @(negedge Clock);
    #1;
    win = 1'b0;
  endtask

  always @(negedge Clock) begin
    if (win) begin
      win_cnt  += int'(cmd[win_bit]);
      held_cnt += int'(held[win_bit]);
    end
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("cmd", 32'(cmd), 32'(mon_e.cmd));
      check("held", 32'(held), 32'(mon_e.held));
      check("any_key", 32'(any_key), 32'(mon_e.any));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    kb;
    logic [NK-1:0] en, cl;
    int            len;

    reset   = 1'b0;
    kbData  = KEY_ENTER;
    chan_en = '1;
    clr     = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_cmd", 32'(cmd), 0);
    check("reset_held", 32'(held), 0);
    check("reset_any", 32'(any_key), 0);
    kbData = 8'h00;
    model_reset();
    reset = 1'b1;

    // Single press on a PULSE channel
    cyc(8'h00, 7'b0000001, '0);
    cyc(8'h00, 7'b0000001, '0);
    win_start(0);
    hold(KEY_ENTER, 7'b0000001, 10);
    hold(8'h00, 7'b0000001, 3);
    win_stop();
`ifdef KEY_REPEAT_EN
    check("t1_pulses", win_cnt, 2);
`else
    check("t1_pulses", win_cnt, 1);
`endif
    check("t1_held_clks", held_cnt, 10);

    // Press while disabled is lost
    win_start(0);
    cyc(8'h00, 7'b0000000, '0);
    hold(KEY_ENTER, 7'b0000000, 3);
    hold(KEY_ENTER, 7'b0000001, 4);
    hold(8'h00, 7'b0000001, 2);
    win_stop();
    check("t2_no_pulse", win_cnt, 0);

    // Toggle channel
    hold(KEY_ESC, 7'b0010000, 2);
    hold(8'h00, 7'b0010000, 2);
    check("t3_toggle_on", 32'(cmd[4]), 1);
    hold(KEY_ESC, 7'b0010000, 2);
    hold(8'h00, 7'b0010000, 2);
    check("t3_toggle_off", 32'(cmd[4]), 0);
    hold(KEY_ESC, 7'b0010000, 2);
    cyc(8'h00, 7'b0010000, 7'b0010000);
    cyc(8'h00, 7'b0010000, '0);
    check("t3_clr_wins", 32'(cmd[4]), 0);

    // Hold qualification
    win_start(5);
    hold(KEY_ENTER, 7'b0100000, 3);
    hold(8'h00, 7'b0100000, 2);
    win_stop();
    check("t4_short_hold", win_cnt, 0);
    win_start(5);
    hold(KEY_ENTER, 7'b0100000, 6);
    hold(8'h00, 7'b0100000, 2);
    win_stop();
    check("t4_long_hold_clks", win_cnt, 3);

    // Direct code change, then async reset mid-hold
    hold(KEY_ENTER, '1, 3);
    cyc(KEY_SPACE, '1, '0);
    check("t5_level_ch3", 32'(cmd[3]), 1);
    check("t5_held_ch0", 32'(held[0]), 0);
    check("t5_any_key", 32'(any_key), 1);
    hold(KEY_SPACE, '1, 2);
    @(negedge Clock);
    #1;
    reset = 1'b0;
    #1;
    check("t5_async_cmd", 32'(cmd), 0);
    check("t5_async_held", 32'(held), 0);
    check("t5_async_any", 32'(any_key), 0);
    repeat (2) @(posedge Clock);
    #1;
    kbData  = 8'h00;
    chan_en = '0;
    model_reset();
    reset = 1'b1;

    // Long hold on a PULSE channel (auto-repeat when enabled)
    win_start(0);
    hold(KEY_ENTER, 7'b0000001, 20);
    hold(8'h00, 7'b0000001, 2);
    win_stop();
`ifdef KEY_REPEAT_EN
    check("t6_pulses", win_cnt, 5);
`else
    check("t6_pulses", win_cnt, 1);
`endif

    // Random key sequences
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 7))
        0:       kb = 8'h00;
        1:       kb = KEY_ENTER;
        2:       kb = KEY_1;
        3:       kb = KEY_RSHIFT;
        4:       kb = KEY_SPACE;
        5:       kb = KEY_ESC;
        6:       kb = 8'h11;
        default: kb = 8'($urandom);
      endcase
      en  = NK'($urandom) | NK'($urandom);
      len = $urandom_range(1, 24);
      repeat (len) begin
        if ($urandom_range(0, 7) == 0) en = en ^ (NK'(1) << $urandom_range(0, NK - 1));
        cl = ($urandom_range(0, 11) == 0) ? (NK'(1) << $urandom_range(0, NK - 1)) : '0;
        cyc(kb, en, cl);
      end
    end
    hold(8'h00, '1, 3);

    @(negedge Clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
